// File: rtl/multicore_sched.sv
// Staggered reset release for a bank of identical cores plus a one-deep output arbiter.
// Define MC_RR_ARB_EN for round-robin grants; otherwise the lowest requesting index wins.
module multicore_sched #(
    parameter int NCORES  = 39,
    parameter int DW      = 32,
    parameter int STAGGER = 825,
    parameter int CNTW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    output logic [NCORES-1:0]      core_rst,
    input  logic [2*NCORES-1:0]    core_out_en,
    input  logic [DW*NCORES-1:0]   core_io_out,
    output logic [DW-1:0]          io_out,
    output logic [1:0]             out_en,
    output logic                   all_up,
    output logic                   collide,
    output logic [CNTW-1:0]        coll_cnt
);
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    typedef enum logic [1:0] {IDLE, RELEASE, RUN} state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [SW-1:0]           cnt;
    logic [NCORES-1:0]       req;
    logic [NCORES-1:0][DW-1:0] core_data;
    logic [IW-1:0]           gnt;
    logic                    gvld;
    logic                    multi;

    assign core_data = core_io_out;

    // A core still held in reset never competes, whatever its strobe says.
    for (genvar k = 0; k < NCORES; k++) begin : g_req
        assign req[k] = (core_out_en[2*k +: 2] == 2'b01) & ~core_rst[k];
    end

    assign multi = $countones(req) > 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            core_rst <= '1;
            all_up   <= 1'b0;
        end else if (halt) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            core_rst <= '1;
            all_up   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= RELEASE;
                    core_rst[0] <= 1'b0;
                    idx         <= '0;
                    cnt         <= '0;
                end
                RELEASE: begin
                    // Last core already out of reset: one settling edge, then RUN.
                    if (idx == IW'(NCORES - 1)) begin
                        state  <= RUN;
                        all_up <= 1'b1;
                    end else if (cnt == SW'(STAGGER - 1)) begin
                        cnt               <= '0;
                        idx               <= idx + 1'b1;
                        core_rst[idx + 1'b1] <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN:     all_up <= 1'b1;
                default: state  <= IDLE;
            endcase
        end
    end

`ifdef MC_RR_ARB_EN
    logic [IW-1:0] ptr;

    always_comb begin
        int k;
        gnt  = '0;
        gvld = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            k = i + int'(ptr);
            if (k >= NCORES) k = k - NCORES;
            if (!gvld && req[k]) begin
                gvld = 1'b1;
                gnt  = IW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (gvld)
            ptr <= (gnt == IW'(NCORES - 1)) ? '0 : gnt + 1'b1;
    end
`else
    always_comb begin
        gnt  = '0;
        gvld = 1'b0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                gvld = 1'b1;
                gnt  = IW'(i);
            end
        end
    end
`endif

    // Losing requests are dropped; io_out keeps its last value on idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_out   <= '0;
            out_en   <= 2'b00;
            collide  <= 1'b0;
            coll_cnt <= '0;
        end else begin
            out_en  <= gvld ? 2'b01 : 2'b00;
            collide <= multi;
            if (gvld)
                io_out <= core_data[gnt];
            if (multi && (coll_cnt != '1))
                coll_cnt <= coll_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_multicore_sched.sv
// Bench for multicore_sched: NCORES=4, STAGGER=3, CNTW=2; works with or without MC_RR_ARB_EN.
module tb_multicore_sched;
    localparam int NC = 4;
    localparam int DW = 16;
    localparam int ST = 3;
    localparam int CW = 2;

    logic               clk, rst, start, halt;
    logic [NC-1:0]      core_rst;
    logic [2*NC-1:0]    core_out_en;
    logic [DW*NC-1:0]   core_io_out;
    logic [DW-1:0]      io_out;
    logic [1:0]         out_en;
    logic               all_up, collide;
    logic [CW-1:0]      coll_cnt;

    multicore_sched #(.NCORES(NC), .DW(DW), .STAGGER(ST), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .core_rst(core_rst), .core_out_en(core_out_en), .core_io_out(core_io_out),
        .io_out(io_out), .out_en(out_en), .all_up(all_up),
        .collide(collide), .coll_cnt(coll_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]            en;
        logic [3:0][DW-1:0]    d;
        logic                  vld;
        logic [DW-1:0]         rr;
        logic [DW-1:0]         fp;
        logic                  coll;
    } vec_t;

    typedef struct {
        logic [1:0]    en;
        logic [DW-1:0] io;
        logic          coll;
        logic [CW-1:0] cnt;
    } exp_t;

    vec_t tbl[9];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [7:0] en, input logic [DW-1:0] base,
                                 input logic vld, input logic [DW-1:0] rr,
                                 input logic [DW-1:0] fp, input logic coll);
        vec_t v;
        v.en = en;
        for (int k = 0; k < NC; k++) v.d[k] = base + DW'(k);
        v.vld = vld; v.rr = rr; v.fp = fp; v.coll = coll;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NC-1:0] exp_rst;
        logic [CW-1:0] cnt_m;
        exp_t ex, got;

        // en byte: {core3, core2, core1, core0} two bits each
        tbl[0] = mkv(8'b01_00_01_01, 16'h0100, 1'b1, 16'h0100, 16'h0100, 1'b1);
        tbl[1] = mkv(8'b01_00_01_01, 16'h0110, 1'b1, 16'h0111, 16'h0110, 1'b1);
        tbl[2] = mkv(8'b01_00_01_01, 16'h0120, 1'b1, 16'h0123, 16'h0120, 1'b1);
        tbl[3] = mkv(8'b00_01_00_00, 16'h0130, 1'b1, 16'hFFFB, 16'hFFFB, 1'b0);
        tbl[3].d[2] = 16'hFFFB;
        tbl[4] = mkv(8'b10_11_01_01, 16'h0140, 1'b1, 16'h0140, 16'h0140, 1'b1);
        tbl[5] = mkv(8'b01_11_10_01, 16'h0150, 1'b1, 16'h0153, 16'h0150, 1'b1);
        tbl[6] = mkv(8'b00_10_11_00, 16'h0160, 1'b0, 16'h0153, 16'h0150, 1'b0);
        tbl[7] = mkv(8'b01_00_00_00, 16'h0170, 1'b1, 16'h0173, 16'h0173, 1'b0);
        tbl[8] = mkv(8'b00_00_00_00, 16'h0180, 1'b0, 16'h0173, 16'h0173, 1'b0);

        rst = 1'b0; start = 1'b0; halt = 1'b0;
        core_out_en = '0; core_io_out = '0;
        #12;
        chk("rst_core_rst", 64'(core_rst), 64'hF);
        chk("rst_io_out",   64'(io_out),   64'h0);
        chk("rst_out_en",   64'(out_en),   64'h0);
        chk("rst_all_up",   64'(all_up),   64'h0);
        chk("rst_collide",  64'(collide),  64'h0);
        chk("rst_coll_cnt", 64'(coll_cnt), 64'h0);
        rst = 1'b1;

        // edge 0, then start sampled at edge 1
        step();
        start = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            step();
            start = 1'b0;
            for (int k = 0; k < NC; k++) exp_rst[k] = (e >= 1 + ST * k) ? 1'b0 : 1'b1;
            chk($sformatf("rel_core_rst_e%0d", e), 64'(core_rst), 64'(exp_rst));
            chk($sformatf("rel_all_up_e%0d", e),   64'(all_up),   64'(e >= 11));
        end

        cnt_m = '0;
        for (int i = 0; i < 9; i++) begin
            core_out_en = tbl[i].en;
            core_io_out = tbl[i].d;
            ex.en   = tbl[i].vld ? 2'b01 : 2'b00;
`ifdef MC_RR_ARB_EN
            ex.io   = tbl[i].rr;
`else
            ex.io   = tbl[i].fp;
`endif
            ex.coll = tbl[i].coll;
            if (tbl[i].coll && cnt_m != '1) cnt_m = cnt_m + 1'b1;
            ex.cnt  = cnt_m;
            sbq.push_back(ex);
            step();
            got = sbq.pop_front();
            chk($sformatf("run%0d_out_en", i),   64'(out_en),   64'(got.en));
            chk($sformatf("run%0d_io_out", i),   64'(io_out),   64'(got.io));
            chk($sformatf("run%0d_collide", i),  64'(collide),  64'(got.coll));
            chk($sformatf("run%0d_coll_cnt", i), 64'(coll_cnt), 64'(got.cnt));
        end
        core_out_en = '0;

        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_start_ignored_rst", 64'(core_rst), 64'h0);
        chk("run_start_ignored_up",  64'(all_up),   64'h1);

        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_core_rst", 64'(core_rst), 64'hF);
        chk("halt_all_up",   64'(all_up),   64'h0);
        chk("halt_io_keep",  64'(io_out),   64'h0173);
        chk("halt_cnt_keep", 64'(coll_cnt), 64'h3);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart1_core_rst", 64'(core_rst), 64'hE);
        repeat (2 * ST) step();
        chk("idx2_core_rst", 64'(core_rst), 64'h8);

        core_out_en = 8'b01_00_00_00;
        core_io_out = {16'h7777, 16'h0, 16'h0, 16'h0};
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_rel_core_rst", 64'(core_rst), 64'hF);
        chk("halt_rel_all_up",   64'(all_up),   64'h0);
        chk("halt_rel_out_en",   64'(out_en),   64'h0);
        step();
        chk("halt_rel_out_en2",  64'(out_en),   64'h0);
        chk("halt_rel_io_keep",  64'(io_out),   64'h0173);
        core_out_en = '0;

        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart2_core_rst", 64'(core_rst), 64'hE);

        repeat (2) step();
        #3 rst = 1'b0;
        #1;
        chk("async_core_rst", 64'(core_rst), 64'hF);
        chk("async_io_out",   64'(io_out),   64'h0);
        chk("async_coll_cnt", 64'(coll_cnt), 64'h0);
        chk("async_all_up",   64'(all_up),   64'h0);
        #1 rst = 1'b1;
        repeat (4) step();
        chk("async_idle_hold", 64'(core_rst), 64'hF);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart3_core_rst", 64'(core_rst), 64'hE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
